// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, reset constants and immediate formats.
package rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [XLEN-1:0] RESET_PC_VAL = 32'h0100_0000;
    localparam logic [XLEN-1:0] NOP_VAL      = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        imm_fmt_e fmt;
        case (opc)
            LOAD, OP_IMM, JALR: fmt = IMM_I;
            STORE:              fmt = IMM_S;
            BRANCH:             fmt = IMM_B;
            LUI, AUIPC:         fmt = IMM_U;
            JAL:                fmt = IMM_J;
            default:            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file: two bypassed read ports, one write port, x0 hardwired.
module register_file
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Same-cycle write-back is forwarded so the reader sees the new value.
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (w_wr_en && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (w_wr_en && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: IF/ID register, field/immediate decode, operand read and load-use stall.
module decode
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = rv32_pkg::RESET_PC_VAL,
    parameter logic [31:0] NOP      = rv32_pkg::NOP_VAL
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm
);

    logic        r_v;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_hazard;
    imm_fmt_e    w_fmt;

    // IF/ID register: flush beats stall beats load; flush keeps the PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v     <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= NOP;
        end else if (flush) begin
            r_v     <= 1'b0;
            r_instr <= NOP;
        end else if (!w_hazard) begin
            r_v     <= if_valid;
            r_pc    <= if_pc;
            r_instr <= if_instruction;
        end
    end

    assign id_pc          = r_pc;
    assign id_instruction = r_instr;
    assign opcode         = r_instr[6:0];
    assign rd             = r_instr[11:7];
    assign funct3         = r_instr[14:12];
    assign rs1            = r_instr[19:15];
    assign rs2            = r_instr[24:20];
    assign funct7         = r_instr[31:25];

    assign w_uses_rs1 = !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
    assign w_uses_rs2 = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);

    assign w_hazard = r_v && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((w_uses_rs1 && (ex_rd == rs1)) || (w_uses_rs2 && (ex_rd == rs2)));

    assign stall    = w_hazard;
    assign id_valid = r_v && !w_hazard && !flush;

    assign w_fmt = imm_fmt(opcode);

    always_comb begin
        imm = '0;
        case (w_fmt)
            IMM_I:   imm = {{20{r_instr[31]}}, r_instr[31:20]};
            IMM_S:   imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
            IMM_B:   imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                            r_instr[30:25], r_instr[11:8], 1'b0};
            IMM_U:   imm = {r_instr[31:12], 12'b0};
            IMM_J:   imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                            r_instr[20], r_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    register_file u_regfile (
        .clk      (clock),
        .rst_n    (reset),
        .i_we     (wb_we),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (rs1),
        .i_raddr2 (rs2),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        flush;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;

    decode dut (
        .clock          (clock),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .imm            (imm)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic        m_v;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_regs [32];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_v     = 1'b0;
        m_pc    = 32'h0100_0000;
        m_instr = 32'h0000_0013;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] x);
        logic [31:0] r;
        case (x[6:0])
            7'h03, 7'h13, 7'h67: r = 32'($signed(x) >>> 20);
            7'h23: r = (32'($signed(x) >>> 20) & ~32'h1f) | 32'(x[11:7]);
            7'h63: r = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            7'h37, 7'h17: r = x & 32'hFFFF_F000;
            7'h6f: r = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] o);
        return !(o == 7'h37 || o == 7'h17 || o == 7'h6f);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] o);
        return (o == 7'h33 || o == 7'h23 || o == 7'h63);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_we && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit model_stall();
        bit hit1, hit2;
        hit1 = reads_rs1(m_instr[6:0]) && (ex_rd == m_instr[19:15]);
        hit2 = reads_rs2(m_instr[6:0]) && (ex_rd == m_instr[24:20]);
        return m_v && ex_valid && ex_mem_read && (ex_rd != 5'd0) && (hit1 || hit2);
    endfunction

    task automatic compare_all();
        bit es;
        es = model_stall();
        chk("stall",          32'(stall),    32'(es));
        chk("id_valid",       32'(id_valid), 32'(m_v && !es && !flush));
        chk("id_pc",          id_pc,         m_pc);
        chk("id_instruction", id_instruction, m_instr);
        chk("opcode",         32'(opcode),   32'(m_instr[6:0]));
        chk("funct3",         32'(funct3),   32'(m_instr[14:12]));
        chk("funct7",         32'(funct7),   32'(m_instr[31:25]));
        chk("rs1",            32'(rs1),      32'(m_instr[19:15]));
        chk("rs2",            32'(rs2),      32'(m_instr[24:20]));
        chk("rd",             32'(rd),       32'(m_instr[11:7]));
        chk("rs1_data",       rs1_data,      model_read(m_instr[19:15]));
        chk("rs2_data",       rs2_data,      model_read(m_instr[24:20]));
        chk("imm",            imm,           model_imm(m_instr));
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        bit s;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            s = model_stall();
            if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (flush) begin
                m_v     = 1'b0;
                m_instr = 32'h0000_0013;
            end else if (!s) begin
                m_v     = if_valid;
                m_pc    = if_pc;
                m_instr = if_instruction;
            end
        end
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] ins);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_instruction = ins;
    endtask

    task automatic clear_side();
        flush       = 1'b0;
        ex_valid    = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        wb_we       = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
    endtask

    logic [6:0] opcs [10];

    initial begin
        opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h0f};
        reset = 1'b0;
        if_valid = 1'b0;
        if_pc = 32'h0;
        if_instruction = 32'h0;
        clear_side();
        model_reset();
        #12;

        // Reset values
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_stall",    32'(stall),    32'h0);
        chk("rst_id_pc",    id_pc,         32'h0100_0000);
        chk("rst_id_instr", id_instruction, 32'h0000_0013);
        chk("rst_imm",      imm,           32'h0);
        chk("rst_rd",       32'(rd),       32'h0);
        chk("rst_rs1",      32'(rs1),      32'h0);
        chk("rst_rs1_data", rs1_data,      32'h0);
        chk("rst_rs2_data", rs2_data,      32'h0);
        compare_all();

        // addi x1,x0,5
        reset = 1'b1;
        present(32'h0100_0000, 32'h0050_0093);
        #1; compare_all(); tick();
        present(32'h0100_0004, 32'hFE20_AE23);
        #1;
        chk("addi_id_valid", 32'(id_valid), 32'h1);
        chk("addi_rd",       32'(rd),       32'h1);
        chk("addi_rs1",      32'(rs1),      32'h0);
        chk("addi_imm",      imm,           32'h5);
        chk("addi_rs1_data", rs1_data,      32'h0);
        compare_all(); tick();

        // sw x2,-4(x1) then jal x0,-8
        present(32'h0100_0008, 32'hFF9F_F06F);
        #1;
        chk("sw_imm", imm, 32'hFFFF_FFFC);
        compare_all(); tick();
        present(32'h0100_000C, 32'h0011_8233);
        #1;
        chk("jal_imm", imm, 32'hFFFF_FFF8);
        compare_all(); tick();

        // Load-use: lw x3 in EX while add x4,x3,x1 in ID
        present(32'h0100_0010, 32'h0000_0013);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
        #1;
        chk("lu_stall",    32'(stall),    32'h1);
        chk("lu_id_valid", 32'(id_valid), 32'h0);
        compare_all(); tick();
        clear_side();
        present(32'h0100_0010, 32'h0011_8233);
        #1;
        chk("lu_post_stall", 32'(stall),     32'h0);
        chk("lu_post_valid", 32'(id_valid),  32'h1);
        chk("lu_held_instr", id_instruction, 32'h0011_8233);
        compare_all(); tick();

        // Flush together with a stall
        present(32'h0100_0014, 32'h0050_0333);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; flush = 1'b1;
        #1;
        chk("fl_stall",    32'(stall),    32'h1);
        chk("fl_id_valid", 32'(id_valid), 32'h0);
        compare_all(); tick();
        clear_side();
        #1;
        chk("fl_post_valid", 32'(id_valid),  32'h0);
        chk("fl_post_instr", id_instruction, 32'h0000_0013);
        compare_all(); tick();

        // Write-back bypass on rs2=5 (add x6,x0,x5)
        present(32'h0100_0018, 32'h0050_0333);
        #1; compare_all(); tick();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("byp_rs2_data", rs2_data, 32'hDEAD_BEEF);
        compare_all(); tick();
        clear_side();
        present(32'h0100_001C, 32'h0000_0333);
        #1;
        chk("x5_written", rs2_data, 32'hDEAD_BEEF);
        compare_all(); tick();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        #1;
        chk("x0_rs1_data", rs1_data, 32'h0);
        chk("x0_rs2_data", rs2_data, 32'h0);
        compare_all(); tick();
        clear_side();

        // Reset asserted mid-cycle during a hazard on x5
        present(32'h0100_0020, 32'h0050_0333);
        #1; compare_all(); tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        chk("rs_pre_stall", 32'(stall), 32'h1);
        compare_all();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rs_stall_drop", 32'(stall),    32'h0);
        chk("rs_valid_drop", 32'(id_valid), 32'h0);
        compare_all();
        #2;
        reset = 1'b1;
        clear_side();
        present(32'h0100_0000, 32'h0050_0333);
        #1; compare_all(); tick();
        #1;
        chk("rs_x5_cleared", rs2_data, 32'h0);
        compare_all();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0]   = opcs[$urandom_range(0, 9)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            if_valid       = ($urandom_range(0, 9) < 8);
            if_pc          = $urandom & 32'hFFFF_FFFC;
            if_instruction = ins;
            flush          = ($urandom_range(0, 9) == 0);
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_mem_read    = ($urandom_range(0, 1) == 0);
            ex_rd          = 5'($urandom_range(0, 7));
            wb_we          = ($urandom_range(0, 1) == 0);
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            #1;
            compare_all();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

RV32I decode stage, directly downstream of `fetch`. Captures `pc_out`/`instruction` from `fetch` into an IF/ID pipeline register, decodes fields and immediates, and reads two operands from the architectural register file with write-back bypass. Detects load-use hazards and returns `stall` to `fetch`. Consumes the execute stage's redirect (`br_taken || jp_taken`) as a flush.

## Interface
Parameters:
- `RESET_PC`, 32'h01000000, reset value of captured PC; matches `fetch` reset PC.
- `NOP`, 32'h00000013, instruction held in IF/ID when reset or flushed (`addi x0,x0,0`).

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low: `reset`=0 clears all state immediately; deassertion is synchronous to `clock` upstream.
- `if_valid`  in  1  `fetch.valid`.
- `if_pc`  in  32  `fetch.pc_out`.
- `if_instruction`  in  32  `fetch.instruction`.
- `flush`  in  1  execute redirect (`br_taken || jp_taken`).
- `ex_valid`, `ex_mem_read`  in  1 each  instruction in EX is a valid load.
- `ex_rd`  in  5  destination of the instruction in EX.
- `wb_we`  in  1  write-back enable.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  32  write-back value.
- `stall`  out  1  to `fetch.stall`; hold PC.
- `id_valid`  out  1  decoded instruction is valid this cycle (bubble when 0).
- `id_pc`, `id_instruction`  out  32 each  IF/ID register contents.
- `opcode`  out  7; `funct3`  out  3; `funct7`  out  7.
- `rs1`, `rs2`, `rd`  out  5 each.
- `rs1_data`, `rs2_data`  out  32 each.
- `imm`  out  32  sign-extended immediate.

## Operation
- IF/ID register fields: `v`, `pc`, `instr`. Priority each posedge: flush > stall > load.
  - flush: `v`←0, `instr`←NOP; `pc` unchanged.
  - stall (no flush): hold all fields.
  - otherwise: `v`←`if_valid`, `pc`←`if_pc`, `instr`←`if_instruction`.
- Field extraction from `instr`: standard RV32I bit positions, combinational.
- Immediate by opcode:
  - I-type (0000011, 0010011, 1100111): `instr[31:20]`, sign-extended.
  - S (0100011): `{instr[31:25], instr[11:7]}`.
  - B (1100011): `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U (0110111, 0010111): `{instr[31:12], 12'b0}`.
  - J (1101111): `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - Others: 0.
- Operand usage:
  - `uses_rs1` = opcode not in {LUI, AUIPC, JAL}.
  - `uses_rs2` = opcode in {R 0110011, S, B}.
- `stall` = `v` & `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & ((`uses_rs1` & `ex_rd`==`rs1`) | (`uses_rs2` & `ex_rd`==`rs2`)).
- `id_valid` = `v` & ~`stall` & ~`flush`; a stalled instruction is issued as a bubble and is re-presented next cycle.
- Register file, 32×32:
  - Write at posedge when `wb_we` & `wb_rd`≠0.
  - x0 always reads 0.
  - Reads are combinational with bypass: if `wb_we` & `wb_rd`≠0 & `wb_rd`==`rsN`, then `rsN_data`=`wb_data`.

## Timing
- Reset (`reset`=0), asynchronous:
  - `v`=0, `pc`=`RESET_PC`, `instr`=NOP, all 32 registers=0.
  - Outputs: `id_valid`=0, `stall`=0, `id_pc`=0x01000000, `id_instruction`=0x00000013, `imm`=0, `rd`=`rs1`=0, `rs1_data`=`rs2_data`=0.
- Latency: instruction presented by `fetch` in cycle N appears decoded in cycle N+1, absent stall/flush.
- `stall` is combinational from IF/ID and EX inputs. Asserted for exactly one cycle per load-use hazard, because EX receives a bubble next cycle.
- Flush and stall in the same cycle: flush wins; `stall` still reflects the hazard combinationally, but `fetch` redirects because its branch/jump priority is higher.
- Write-back and read of the same register in the same cycle: reader sees the new value.
- Write to x0 is ignored; reading x0 returns 0 even while `wb_rd`=0 with `wb_we`=1.
- Reset mid-stall: state clears immediately and `stall` drops the same instant.

## Structure
- Shared package `rv32_pkg`:
  - Opcode localparams (LOAD, OP_IMM, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP).
  - RESET_PC and NOP constants.
  - Immediate-format enum.
- One sub-module: `register_file` (2 read ports with bypass, 1 write port, x0 hardwired, async active-low reset). Instantiated once in `decode`.

## Test plan
- Reset, then release with `if_valid`=1, `if_pc`=0x01000000, `if_instruction`=0x00500093 (addi x1,x0,5) -> next cycle `id_valid`=1, `rd`=1, `rs1`=0, `imm`=5, `rs1_data`=0.
- Decode `sw x2,-4(x1)` (0xFE20AE23) -> `imm`=0xFFFFFFFC; decode `jal x0,-8` (0xFF9FF06F) -> `imm`=0xFFFFFFF8.
- EX holds `lw x3` (`ex_mem_read`=1, `ex_rd`=3) while ID holds `add x4,x3,x1` -> `stall`=1 and `id_valid`=0 for one cycle; IF/ID held; next cycle `stall`=0 and `id_valid`=1.
- `flush`=1 together with a stall -> next cycle `id_valid`=0 and `id_instruction`=0x00000013.
- `wb_we`=1, `wb_rd`=5, `wb_data`=0xDEADBEEF while ID reads `rs2`=5 -> `rs2_data`=0xDEADBEEF in the same cycle. Repeat with `wb_rd`=0 -> x0 reads 0.
- Assert `reset`=0 mid-cycle while a hazard is present -> `stall` and `id_valid` drop to 0 immediately; register x5 reads 0 after release.
